// File: rtl/ahb_byte_master_pkg.sv
// Shared definitions for the byte-command AHB-Lite master: FSM encoding,
// AHB transfer constants and the command/response byte values.
package ahb_byte_master_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        APHASE   = 3'd3,
        DPHASE   = 3'd4,
        RESP     = 3'd5
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    // Word transfers always start on a 4-byte boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ahb_byte_master_shreg.sv
// 4-byte little-endian assembler/serializer. Bytes shifted in land at the
// top and move down, so the first byte ends up in [7:0]. Shifting out
// presents [7:0] first. A 2-bit counter flags the fourth byte.
module ahb_byte_master_shreg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [31:0] load_word_i,
    input  logic        shift_in_i,
    input  logic [7:0]  byte_i,
    input  logic        shift_out_i,
    output logic [31:0] word_nxt_o,
    output logic [7:0]  byte_o,
    output logic        last_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    // Next-state selection: clear, parallel load, shift in, shift out or hold.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            word_d = 32'h0000_0000;
            cnt_d  = 2'd0;
        end else if (load_i) begin
            word_d = load_word_i;
            cnt_d  = 2'd0;
        end else if (shift_in_i) begin
            word_d = {byte_i, word_q[31:8]};
            cnt_d  = cnt_q + 2'd1;
        end else if (shift_out_i) begin
            word_d = {8'h00, word_q[31:8]};
            cnt_d  = cnt_q + 2'd1;
        end else begin
            word_d = word_q;
            cnt_d  = cnt_q;
        end
    end

    // Word and byte-counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= 32'h0000_0000;
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_nxt_o = word_d;
    assign byte_o     = word_q[7:0];
    assign last_o     = (cnt_q == 2'd3);

endmodule

// File: rtl/ahb_byte_master.sv
// Byte-command to AHB-Lite single-word master.
// Commands: 'W' + addr[4 LE] + data[4 LE] -> 06; 'R' + addr[4 LE] ->
// rdata[4 LE] + 06; any other opcode -> 15.
// Optional feature macro: AHB_BYTE_MASTER_TIMEOUT_EN aborts a data phase
// with a 15 response after TIMEOUT_CYCLES cycles of HREADY low.
module ahb_byte_master
    import ahb_byte_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    output logic        busy
);

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_data_q, rsp_data_d;
    logic [7:0]  rsp_code_q, rsp_code_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [2:0]  hsize_q;
    logic        rx_ready_q, rx_ready_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;

    logic        sh_clr_s, sh_load_s, sh_in_s, sh_out_s, sh_last_s;
    logic [31:0] sh_word_nxt_s;
    logic [7:0]  sh_byte_s;
    logic        rx_fire_s;
    logic        to_hit_s;

    assign rx_fire_s = rx_valid && rx_ready_q;

    ahb_byte_master_shreg u_shreg (
        .clk_i       (HCLK),
        .rst_i       (HRESET),
        .clr_i       (sh_clr_s),
        .load_i      (sh_load_s),
        .load_word_i (HRDATA),
        .shift_in_i  (sh_in_s),
        .byte_i      (rx_data),
        .shift_out_i (sh_out_s),
        .word_nxt_o  (sh_word_nxt_s),
        .byte_o      (sh_byte_s),
        .last_o      (sh_last_s)
    );

`ifdef AHB_BYTE_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Count consecutive HREADY-low cycles of the data phase.
    always_comb begin
        to_cnt_d = '0;
        if ((state_q == DPHASE) && !HREADY) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // Fires on the last permitted wait cycle.
    assign to_hit_s = (state_q == DPHASE) && !HREADY &&
                      (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout the data phase simply waits for HREADY.
    assign to_hit_s = 1'b0;
`endif

    // Command parser FSM, response sequencer and registered-output next state.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_code_d = rsp_code_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hwdata_d   = hwdata_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        sh_clr_s   = 1'b0;
        sh_load_s  = 1'b0;
        sh_in_s    = 1'b0;
        sh_out_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_fire_s) begin
                    if (rx_data == CMD_WR) begin
                        wr_d     = 1'b1;
                        sh_clr_s = 1'b1;
                        state_d  = GET_ADDR;
                    end else if (rx_data == CMD_RD) begin
                        wr_d     = 1'b0;
                        sh_clr_s = 1'b1;
                        state_d  = GET_ADDR;
                    end else begin
                        rsp_code_d = RSP_NAK;
                        rsp_data_d = 1'b0;
                        state_d    = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GET_ADDR: begin
                if (rx_fire_s) begin
                    sh_in_s = 1'b1;
                    if (sh_last_s) begin
                        addr_d  = sh_word_nxt_s;
                        state_d = wr_q ? GET_DATA : APHASE;
                    end else begin
                        state_d = GET_ADDR;
                    end
                end else begin
                    state_d = GET_ADDR;
                end
            end
            GET_DATA: begin
                if (rx_fire_s) begin
                    sh_in_s = 1'b1;
                    if (sh_last_s) begin
                        wdata_d = sh_word_nxt_s;
                        state_d = APHASE;
                    end else begin
                        state_d = GET_DATA;
                    end
                end else begin
                    state_d = GET_DATA;
                end
            end
            APHASE: begin
                if (HREADY) begin
                    hwdata_d = wr_q ? wdata_q : hwdata_q;
                    state_d  = DPHASE;
                end else begin
                    state_d = APHASE;
                end
            end
            DPHASE: begin
                if (HREADY) begin
                    rsp_code_d = RSP_ACK;
                    rsp_data_d = !wr_q;
                    sh_load_s  = !wr_q;
                    state_d    = RESP;
                end else if (to_hit_s) begin
                    rsp_code_d = RSP_NAK;
                    rsp_data_d = 1'b0;
                    state_d    = RESP;
                end else begin
                    state_d = DPHASE;
                end
            end
            RESP: begin
                // First RESP cycle loads the output register; afterwards each
                // handshake either loads the next byte or finishes.
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = rsp_data_q ? sh_byte_s : rsp_code_q;
                end else if (tx_ready) begin
                    if (rsp_data_q) begin
                        sh_out_s = 1'b1;
                        if (sh_last_s) begin
                            rsp_data_d = 1'b0;
                            tx_data_d  = rsp_code_q;
                        end else begin
                            tx_data_d = sh_word_nxt_s[7:0];
                        end
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end else begin
                    tx_valid_d = tx_valid_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Address-phase outputs change only when a transfer starts.
        if ((state_d == APHASE) && (state_q != APHASE)) begin
            haddr_d  = word_align(addr_d);
            hwrite_d = wr_q;
        end else begin
            haddr_d  = haddr_q;
            hwrite_d = hwrite_q;
        end

        htrans_d   = (state_d == APHASE) ? HTRANS_NONSEQ : HTRANS_IDLE;
        rx_ready_d = (state_d == IDLE) || (state_d == GET_ADDR) || (state_d == GET_DATA);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            rsp_data_q <= 1'b0;
            rsp_code_q <= 8'h00;
            haddr_q    <= 32'h0000_0000;
            hwrite_q   <= 1'b0;
            hwdata_q   <= 32'h0000_0000;
            htrans_q   <= HTRANS_IDLE;
            hsize_q    <= HSIZE_WORD;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_code_q <= rsp_code_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            hwdata_q   <= hwdata_d;
            htrans_q   <= htrans_d;
            hsize_q    <= HSIZE_WORD;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign HADDR    = haddr_q;
    assign HTRANS   = htrans_q;
    assign HWRITE   = hwrite_q;
    assign HSIZE    = hsize_q;
    assign HWDATA   = hwdata_q;
    assign rx_ready = rx_ready_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ahb_byte_master.sv
// Scoreboard bench for ahb_byte_master: stimulus pushes expected AHB
// transfers, response bytes and latencies; independent monitors compare.
module tb_ahb_byte_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        busy;

    always #5 HCLK = ~HCLK;

    ahb_byte_master #(.TIMEOUT_CYCLES(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .busy(busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } ahb_t;

    ahb_t        exp_ahb[$];
    logic [7:0]  exp_tx[$];
    int          exp_lat[$];
    logic [31:0] mem [bit [31:0]];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;
    bit tx_hold  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    initial forever begin
        @(posedge HCLK);
        cyc++;
    end

    // tx_ready: random acceptance, or held low while tx_hold is set.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge HCLK);
            #1;
            tx_ready = tx_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Response monitor: byte scoreboard, stability, latency, rx backpressure.
    initial begin
        logic       prev_v;
        logic       prev_r;
        logic [7:0] prev_d;
        int         lat;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_d = 8'h00;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                prev_v = 1'b0;
            end else begin
                if (rx_valid && rx_ready) last_acc = cyc + 1;
                if (prev_v && !prev_r) begin
                    check("tx_valid_held", {31'd0, tx_valid}, 32'd1);
                    check("tx_data_stable", {24'd0, tx_data}, {24'd0, prev_d});
                end
                if (tx_valid && !prev_v) begin
                    if (exp_lat.size() == 0) begin
                        bound_fail("unexpected_response_start");
                    end else begin
                        lat = exp_lat.pop_front();
                        if (lat >= 0) check("latency", cyc - last_acc, lat);
                    end
                end
                if (tx_valid) check("rx_ready_low_in_resp", {31'd0, rx_ready}, 32'd0);
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_unexpected: got 0x%0h expected none", tx_data);
                    end else begin
                        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
                    end
                end
                prev_v = tx_valid;
                prev_r = tx_ready;
                prev_d = tx_data;
            end
        end
    end

    // AHB slave: checks each NONSEQ against the expected queue, inserts waits.
    initial begin
        ahb_t t;
        bit   aborted;
        HREADY = 1'b1;
        HRDATA = 32'h0;
        forever begin
            @(negedge HCLK);
            if (!HRESET && HTRANS == 2'b10 && HREADY) begin
                if (exp_ahb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ahb_unexpected: got addr 0x%0h expected no transfer", HADDR);
                end else begin
                    t = exp_ahb.pop_front();
                    check("HADDR", HADDR, t.addr);
                    check("HWRITE", {31'd0, HWRITE}, {31'd0, t.wr});
                    check("HSIZE", {29'd0, HSIZE}, 32'd2);
                    aborted = 1'b0;
                    @(posedge HCLK);
                    #1;
                    for (int k = 0; k < t.waits && !aborted; k++) begin
                        HREADY = 1'b0;
                        HRDATA = $urandom;
                        @(posedge HCLK);
                        #1;
                        if (HRESET || tx_valid || !busy) aborted = 1'b1;
                    end
                    if (!aborted) begin
                        HREADY = 1'b1;
                        HRDATA = t.wr ? $urandom : t.rdata;
                        @(negedge HCLK);
                        if (t.wr) check("HWDATA", HWDATA, t.wdata);
                        @(posedge HCLK);
                        #1;
                        HRDATA = $urandom;
                    end else begin
                        HREADY = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!done) begin
            @(negedge HCLK);
            if (rx_ready) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 3000) begin
                    bound_fail("rx_accept");
                    done = 1'b1;
                end
            end
        end
        @(posedge HCLK);
        #1;
        rx_valid = 1'b0;
        rx_data  = $urandom;
        repeat ($urandom_range(0, 1)) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    // kind: 0 bad opcode, 1 write, 2 read, 3 read that never completes.
    task automatic issue(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [7:0] op);
        ahb_t        t;
        logic [31:0] a;
        logic [31:0] rd;
        a = {addr[31:2], 2'b00};
        if (kind == 0) begin
            exp_tx.push_back(8'h15);
            exp_lat.push_back(-1);
            send_byte(op);
        end else begin
            if (kind == 1) begin
                t = '{a, 1'b1, wdata, 32'h0, waits};
                mem[a] = wdata;
                exp_tx.push_back(8'h06);
                exp_lat.push_back(3 + waits);
            end else if (kind == 2) begin
                rd = mem.exists(a) ? mem[a] : $urandom;
                mem[a] = rd;
                t = '{a, 1'b0, 32'h0, rd, waits};
                for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
                exp_tx.push_back(8'h06);
                exp_lat.push_back(3 + waits);
            end else begin
                t = '{a, 1'b0, 32'h0, 32'h0, 1000};
                exp_tx.push_back(8'h15);
                exp_lat.push_back(2 + 8);
            end
            exp_ahb.push_back(t);
            send_byte((kind == 1) ? 8'h57 : 8'h52);
            for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
            if (kind == 1) begin
                for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || busy) && n < 5000) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= 5000) bound_fail("response_drain");
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_HTRANS"}, {30'd0, HTRANS}, 32'd0);
        check({tag, "_HADDR"}, HADDR, 32'd0);
        check({tag, "_HWDATA"}, HWDATA, 32'd0);
        check({tag, "_HWRITE"}, {31'd0, HWRITE}, 32'd0);
        check({tag, "_HSIZE"}, {29'd0, HSIZE}, 32'd2);
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int          n;
        int          kind;
        logic [7:0]  op;
        logic [7:0]  held;
        logic [31:0] addrs [4];
        addrs[0] = 32'h0000_0000;
        addrs[1] = 32'h0000_0104;
        addrs[2] = 32'h8000_0010;
        addrs[3] = 32'hFFFF_FFFC;
        HRESET   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge HCLK);
        #1;
        check_reset_outputs("reset");
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        check("rx_ready_after_reset", {31'd0, rx_ready}, 32'd1);
        tx_hold = 1'b0;

        // Directed write, zero waits.
        issue(1, 32'h2000_1000, 32'hDEAD_BEEF, 0, 8'h00);
        wait_done();

        // Directed read, two wait states.
        mem[32'h4] = 32'h1234_5678;
        issue(2, 32'h0000_0004, 32'h0, 2, 8'h00);
        wait_done();

        // Bad opcode followed by a valid write.
        issue(0, 32'h0, 32'h0, 0, 8'h41);
        issue(1, 32'h0000_0104, 32'hA5A5_0F0F, 1, 8'h00);
        wait_done();

        // Response backpressure: tx_ready low for 10 cycles.
        tx_hold = 1'b1;
        issue(2, 32'h0000_0104, 32'h0, 0, 8'h00);
        n = 0;
        while (!tx_valid && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= 100) bound_fail("bp_tx_valid");
        held = tx_data;
        repeat (10) begin
            @(negedge HCLK);
            check("bp_tx_data", {24'd0, tx_data}, {24'd0, held});
            check("bp_rx_ready", {31'd0, rx_ready}, 32'd0);
        end
        @(posedge HCLK);
        #1;
        tx_hold = 1'b0;
        wait_done();

        // Reset in the middle of a data phase.
        issue(2, 32'h8000_0010, 32'h0, 40, 8'h00);
        n = 0;
        while (HTRANS != 2'b10 && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= 100) bound_fail("mid_reset_aphase");
        repeat (3) begin
            @(posedge HCLK);
            #1;
        end
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        check_reset_outputs("mid_reset");
        exp_tx.delete();
        exp_lat.delete();
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        check("rx_ready_after_mid_reset", {31'd0, rx_ready}, 32'd1);

`ifdef AHB_BYTE_MASTER_TIMEOUT_EN
        // Stuck slave: abort after 8 low cycles with a NAK.
        issue(3, 32'h0000_0200, 32'h0, 0, 8'h00);
        wait_done();
        check("timeout_HTRANS", {30'd0, HTRANS}, 32'd0);
`endif

        // Randomized mix of reads, writes and bad opcodes, back to back.
        repeat (40) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                op = $urandom;
                if (op == 8'h57 || op == 8'h52) op = 8'hFF;
                issue(0, 32'h0, 32'h0, 0, op);
            end else if (kind < 5) begin
                issue(1, addrs[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), $urandom,
                      $urandom_range(0, 3), 8'h00);
            end else begin
                issue(2, addrs[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), 32'h0,
                      $urandom_range(0, 3), 8'h00);
            end
        end
        wait_done();
        check("ahb_queue_drained", exp_ahb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
